// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte transmitter: FSM encoding, line constants
// and the parity helper used when UART_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   DATA_BITS       = 8;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_byte_tx_if.sv
// Byte hand-off from the serial-input monitor plus the UART line status seen by
// the consumer side.
interface uart_byte_tx_if;
    logic       sendUART;
    logic [7:0] data;
    logic       tx;
    logic       busy;
    logic       ovf;

    modport master (output sendUART, data, input tx, busy, ovf);
    modport slave  (input sendUART, data, output tx, busy, ovf);
endinterface

// File: rtl/uart_byte_tx_byte_fifo.sv
// Byte FIFO with wrap-bit pointers; dout shows the head entry whenever !empty.
// A push while full is accepted only if a pop frees the head slot in the same cycle.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] dout,
    output logic                 full,
    output logic                 empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic                 wr_en_s;
    logic                 rd_en_s;

    // Status flags and next pointer values.
    always_comb begin
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty   = (wr_ptr_q == rd_ptr_q);
        rd_en_s = pop & ~empty;
        wr_en_s = push & (~full | rd_en_s);
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; the slot being popped may be overwritten in the same cycle.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    assign dout = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_byte_tx.sv
// Captures upstream bytes on sendUART rising edges, queues them and sends each as
// an 8N1 frame; defining UART_PARITY_EN adds an even-parity bit (8E1).
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic          clk,
    input  logic          reset,
    uart_byte_tx_if.slave bus
);
    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e            state_q, state_d;
    logic [2:0]           sync_q, sync_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tx_q, tx_d;
    logic                 ovf_q, ovf_d;
`ifdef UART_PARITY_EN
    logic                 parity_q, parity_d;
`endif
    logic                 push_s, pop_s, bit_end_s;
    logic                 full_s, empty_s;
    logic [DATA_BITS-1:0] head_s;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .din   (bus.data),
        .pop   (pop_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Edge capture, overflow flag and the transmit FSM next-state logic.
    always_comb begin
        sync_d    = {sync_q[1:0], bus.sendUART};
        push_s    = sync_q[1] & ~sync_q[2];
        ovf_d     = ovf_q | (push_s & full_s & ~pop_s);
        bit_end_s = (baud_q == BAUD_LAST);
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        pop_s     = 1'b0;
`ifdef UART_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = UART_IDLE_LEVEL;
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shreg_d = head_s;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = START;
                    tx_d    = 1'b0;
`ifdef UART_PARITY_EN
                    parity_d = even_parity(head_s);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    baud_d  = '0;
                    state_d = DATA;
                    tx_d    = shreg_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    baud_d = '0;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = UART_IDLE_LEVEL;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (bit_end_s) begin
                    baud_d  = '0;
                    state_d = STOP;
                    tx_d    = UART_IDLE_LEVEL;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end_s) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    tx_d    = UART_IDLE_LEVEL;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                tx_d    = UART_IDLE_LEVEL;
            end
        endcase
    end

    // FSM, counters, capture shift register and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sync_q   <= 3'b000;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shreg_q  <= '0;
            tx_q     <= UART_IDLE_LEVEL;
            ovf_q    <= 1'b0;
`ifdef UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
`ifdef UART_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = (state_q != IDLE) | ~empty_s;
    assign bus.ovf  = ovf_q;

endmodule
